playlist_controller: RTL

Parametrised playback controller for the music player: it owns play/pause state, song selection across `NUM_SONGS` songs, and the playback mode (sequence, repeat-all, repeat-one, optional shuffle). It also applies a volume-scaled, frame-gated output stage to the note player's sample. It sits between the button inputs, the song reader and note player (`song_done`, `reset_play`), and the codec frame interface (`new_frame`). It replaces the fixed 4-song main controller.

---
 rtl/player_pkg.sv | 23 ++
 rtl/playlist_lfsr.sv | 27 ++
 rtl/playlist_controller.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/player_pkg.sv
// Shared types and constants for the playlist controller and its shuffle LFSR.
package player_pkg;

   // Controller FSM states; ADVANCE is the one-cycle restart slot.
   typedef enum logic [1:0] {
      PAUSED  = 2'd0,
      PLAYING = 2'd1,
      ADVANCE = 2'd2
   } state_t;

   // Playback modes in the order mode_btn cycles through them.
   typedef enum logic [1:0] {
      MODE_SEQ     = 2'd0,
      MODE_RPT_ALL = 2'd1,
      MODE_RPT_ONE = 2'd2,
      MODE_SHUFFLE = 2'd3
   } mode_t;

   // 8-bit Fibonacci LFSR: taps 8,6,5,4 map to bits 7,5,4,3.
   localparam logic [7:0] LFSR_SEED = 8'h5A;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/playlist_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick shuffled songs.
// Only instantiated when PLAYLIST_SHUFFLE_EN is defined.
module playlist_lfsr
   import player_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   output logic [7:0] lfsr_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   // Shift left, feeding the XOR of the tapped bits into bit 0.
   always_comb begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
   end

   // Step every cycle; reset reloads the seed.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) lfsr_q <= LFSR_SEED;
      else         lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/playlist_controller.sv
// Playback controller: play/pause, song selection, playback mode, volume
// and the frame-gated, volume-scaled output sample.
// Optional feature macro: PLAYLIST_SHUFFLE_EN (enables mode 3, shuffle).
//
// Event handshake: every button/event input is a single-cycle pulse sampled
// on the rising clock edge; there is no back-pressure. Outputs are registered.
// reset_play_o is high exactly while the FSM sits in ADVANCE.
module playlist_controller
   import player_pkg::*;
#(
   parameter int NUM_SONGS = 4,
   parameter int SONG_BITS = $clog2(NUM_SONGS),
   parameter int SAMPLE_W  = 16,
   parameter int VOL_BITS  = 3
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                play_pause_i,
   input  logic                next_i,
   input  logic                prev_i,
   input  logic                mode_btn_i,
   input  logic                vol_up_i,
   input  logic                vol_down_i,
   input  logic                song_done_i,
   input  logic                new_frame_i,
   input  logic [SAMPLE_W-1:0] voice_sample_i,
   output logic                play_o,
   output logic                reset_play_o,
   output logic [SONG_BITS-1:0] song_o,
   output logic [1:0]          mode_o,
   output logic [VOL_BITS-1:0] volume_o,
   output logic [SAMPLE_W-1:0] sample_o,
   output logic                sample_valid_o,
   output logic [1:0]          state_o
);

   localparam int                  VMAX_I    = 2**VOL_BITS - 1;
   localparam logic [VOL_BITS-1:0] VMAX      = VOL_BITS'(VMAX_I);
   localparam logic [VOL_BITS-1:0] VOL_RESET = VOL_BITS'(VMAX_I / 2 + 1);
   localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);

   state_t               state_q;
   logic                 resume_q;      // 1: return to PLAYING after ADVANCE
   logic                 pend_next_q;   // next/prev seen during ADVANCE
   logic                 pend_prev_q;
   logic                 play_q;
   logic                 reset_play_q;
   logic [SONG_BITS-1:0] song_q;
   mode_t                mode_q, mode_d;
   logic [VOL_BITS-1:0]  volume_q, volume_d;
   logic [SAMPLE_W-1:0]  sample_q, sample_d;
   logic                 sample_valid_q, sample_valid_d;

   logic [SONG_BITS-1:0] song_inc;
   logic [SONG_BITS-1:0] song_dec;
   logic [SONG_BITS-1:0] song_fwd;      // forward step, shuffled when enabled
   logic                 ev_next;
   logic                 ev_prev;
   logic [VOL_BITS-1:0]  shamt;
   logic signed [SAMPLE_W-1:0] shifted;

`ifdef PLAYLIST_SHUFFLE_EN
   logic [7:0]           lfsr_w;
   logic [SONG_BITS-1:0] shuffle_cand;

   playlist_lfsr u_lfsr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .lfsr_o  (lfsr_w)
   );
`endif

   // Song step candidates and the fresh-over-queued event resolution.
   always_comb begin
      song_inc = (song_q == LAST_SONG) ? '0 : song_q + SONG_BITS'(1);
      song_dec = (song_q == '0) ? LAST_SONG : song_q - SONG_BITS'(1);
`ifdef PLAYLIST_SHUFFLE_EN
      shuffle_cand = SONG_BITS'(32'(lfsr_w) % NUM_SONGS);
      if (mode_q == MODE_SHUFFLE)
         song_fwd = (shuffle_cand == song_q) ? song_inc : shuffle_cand;
      else
         song_fwd = song_inc;
`else
      song_fwd = song_inc;
`endif
      // A fresh next/prev replaces whatever was queued during ADVANCE.
      ev_next = next_i | (~prev_i & pend_next_q);
      ev_prev = ~next_i & (prev_i | pend_prev_q);
   end

   // Playback FSM: owns state, resume target, event queue, play, restart pulse and song.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= PAUSED;
         resume_q     <= 1'b0;
         pend_next_q  <= 1'b0;
         pend_prev_q  <= 1'b0;
         play_q       <= 1'b0;
         reset_play_q <= 1'b0;
         song_q       <= '0;
      end else begin
         case (state_q)
            ADVANCE: begin
               state_q      <= resume_q ? PLAYING : PAUSED;
               play_q       <= resume_q;
               reset_play_q <= 1'b0;
               pend_next_q  <= next_i;
               pend_prev_q  <= prev_i & ~next_i;
            end
            default: begin
               pend_next_q  <= 1'b0;
               pend_prev_q  <= 1'b0;
               reset_play_q <= 1'b0;
               if (ev_next) begin
                  song_q       <= song_fwd;
                  state_q      <= ADVANCE;
                  resume_q     <= (state_q == PLAYING);
                  reset_play_q <= 1'b1;
               end else if (ev_prev) begin
                  song_q       <= song_dec;
                  state_q      <= ADVANCE;
                  resume_q     <= (state_q == PLAYING);
                  reset_play_q <= 1'b1;
               end else if (song_done_i && state_q == PLAYING) begin
                  state_q      <= ADVANCE;
                  reset_play_q <= 1'b1;
                  case (mode_q)
                     MODE_RPT_ONE: resume_q <= 1'b1;
                     MODE_SEQ: begin
                        // Sequence mode stops after the last song.
                        if (song_q == LAST_SONG) begin
                           song_q   <= '0;
                           resume_q <= 1'b0;
                        end else begin
                           song_q   <= song_inc;
                           resume_q <= 1'b1;
                        end
                     end
                     default: begin
                        song_q   <= song_fwd;
                        resume_q <= 1'b1;
                     end
                  endcase
               end else if (play_pause_i) begin
                  state_q <= (state_q == PLAYING) ? PAUSED : PLAYING;
                  play_q  <= (state_q != PLAYING);
               end
            end
         endcase
      end
   end

   // Mode, volume and sample next-state; the sample uses the pre-update volume.
   always_comb begin
`ifdef PLAYLIST_SHUFFLE_EN
      mode_d = mode_btn_i ? mode_t'(mode_q + 2'd1) : mode_q;
`else
      if (mode_btn_i)
         mode_d = (mode_q == MODE_RPT_ONE) ? MODE_SEQ : mode_t'(mode_q + 2'd1);
      else
         mode_d = mode_q;
`endif

      volume_d = volume_q;
      if (vol_up_i && !vol_down_i && volume_q != VMAX)
         volume_d = volume_q + VOL_BITS'(1);
      else if (vol_down_i && !vol_up_i && volume_q != '0)
         volume_d = volume_q - VOL_BITS'(1);

      shamt          = VMAX - volume_q;
      shifted        = $signed(voice_sample_i) >>> shamt;
      sample_d       = sample_q;
      sample_valid_d = 1'b0;
      if (new_frame_i) begin
         sample_valid_d = 1'b1;
         if (volume_q == '0 || !play_q || state_q == ADVANCE)
            sample_d = '0;
         else
            sample_d = shifted;
      end
   end

   // Registers for mode, volume and the output sample stage.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mode_q         <= MODE_SEQ;
         volume_q       <= VOL_RESET;
         sample_q       <= '0;
         sample_valid_q <= 1'b0;
      end else begin
         mode_q         <= mode_d;
         volume_q       <= volume_d;
         sample_q       <= sample_d;
         sample_valid_q <= sample_valid_d;
      end
   end

   assign play_o         = play_q;
   assign reset_play_o   = reset_play_q;
   assign song_o         = song_q;
   assign mode_o         = mode_q;
   assign volume_o       = volume_q;
   assign sample_o       = sample_q;
   assign sample_valid_o = sample_valid_q;
   assign state_o        = state_q;

endmodule
